// File: rtl/sram_rr_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM wrapper between NUM_REQ requesters.
// Handles the wrapper's early wdata capture and returns read data through a latency-matched tag pipe.
module sram_rr_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_wmode,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         sram_addr,
    output logic                      sram_en,
    output logic                      sram_wmode,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a command transfers in the cycle where req_valid[i] & req_ready[i];
    // req_ready is a combinational function of req_valid, so requesters must not
    // wait for ready before raising valid. Responses carry no backpressure.

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               s1_en_q, s1_en_d;
    logic               s1_wmode_q, s1_wmode_d;
    logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic               s2_valid_q, s2_valid_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;

    logic [NUM_REQ-1:0] cand;
    logic               found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    scan_id;

    // Scan from the farthest slot down to ptr+1 so the closest candidate overwrites last.
    always_comb begin
        cand    = req_valid & {NUM_REQ{~hold & ~rst}};
        found   = 1'b0;
        win_id  = '0;
        scan_id = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_id = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (cand[scan_id]) begin
                found  = 1'b1;
                win_id = scan_id;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // Wrapper registers wdata one edge before it sees addr/en, so drive it in the accept cycle.
    always_comb begin
        sram_wdata = '0;
        if (found && req_wmode[win_id]) begin
            sram_wdata = req_wdata[int'(win_id)*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        s1_en_d    = found;
        s1_wmode_d = 1'b0;
        s1_addr_d  = '0;
        s1_id_d    = win_id;
        if (found) begin
            ptr_d      = win_id;
            s1_wmode_d = req_wmode[win_id];
            s1_addr_d  = req_addr[int'(win_id)*ADDR_W +: ADDR_W];
        end
        s2_valid_d = s1_en_q & ~s1_wmode_q;
        s2_id_d    = s1_id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= ID_W'(NUM_REQ - 1);
            s1_en_q    <= 1'b0;
            s1_wmode_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_en_q    <= s1_en_d;
            s1_wmode_q <= s1_wmode_d;
            s1_addr_q  <= s1_addr_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign sram_en    = s1_en_q;
    assign sram_wmode = s1_wmode_q;
    assign sram_addr  = s1_addr_q;

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (s2_valid_q) begin
            rsp_valid[s2_id_q] = 1'b1;
            rsp_rdata          = sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_rr_port_arbiter.sv
// Directed bench for sram_rr_port_arbiter with a behavioural model of the 1RW wrapper
// (registered wdata one edge early, registered rdata).
module tb_sram_rr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wmode;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [6:0]  sram_addr;
    logic        sram_en;
    logic        sram_wmode;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_rr_port_arbiter #(.NUM_REQ(2), .ADDR_W(7), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wmode  (req_wmode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .sram_addr  (sram_addr),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Wrapper model: unwritten locations read 8'hEE.
    logic       mdl_clr;
    logic [7:0] mem [128];
    logic [7:0] wd_q;
    logic [7:0] rd_q;

    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < 128; i++) mem[i] <= 8'hEE;
            wd_q <= 8'h00;
            rd_q <= 8'h00;
        end else begin
            wd_q <= sram_wdata;
            if (sram_en) begin
                if (sram_wmode) mem[sram_addr] <= wd_q;
                else            rd_q <= mem[sram_addr];
            end
        end
    end
    assign sram_rdata = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [6:0] a, input logic [7:0] d);
        req_valid[i]          = v;
        req_wmode[i]          = w;
        req_addr[i*7 +: 7]    = a;
        req_wdata[i*8 +: 8]   = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] oh;
        rst = 1'b1; mdl_clr = 1'b1; hold = 1'b0;
        req_valid = '0; req_wmode = '0; req_addr = '0; req_wdata = '0;
        set_req(0, 1'b1, 1'b1, 7'h05, 8'hA5);
        step(); step(); sample();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_sram_en", sram_en, 1'b0);
        chk("rst_sram_wmode", sram_wmode, 1'b0);
        chk("rst_sram_addr", sram_addr, 7'h00);
        chk("rst_sram_wdata", sram_wdata, 8'h00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);

        // Write then read same address by requester 0
        step(); rst = 1'b0; mdl_clr = 1'b0;
        sample();
        chk("t1_ready_wr", req_ready, 2'b01);
        chk("t1_wdata", sram_wdata, 8'hA5);
        step(); set_req(0, 1'b1, 1'b0, 7'h05, 8'h00);
        sample();
        chk("t1_ready_rd", req_ready, 2'b01);
        chk("t1_sram_en_wr", sram_en, 1'b1);
        chk("t1_sram_wmode_wr", sram_wmode, 1'b1);
        chk("t1_sram_addr_wr", sram_addr, 7'h05);
        chk("t1_wdata_rd", sram_wdata, 8'h00);
        step(); set_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
        sample();
        chk("t1_sram_wmode_rd", sram_wmode, 1'b0);
        chk("t1_rsp_early", rsp_valid, 2'b00);
        step(); sample();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_rdata", rsp_rdata, 8'hA5);
        chk("t1_idle_en", sram_en, 1'b0);
        step(); sample();
        chk("t1_rsp_clear", rsp_valid, 2'b00);
        chk("t1_rdata_zero", rsp_rdata, 8'h00);

        // Reset one cycle after a read accept drops the response
        step(); set_req(0, 1'b1, 1'b0, 7'h05, 8'h00);
        sample();
        chk("t5_ready", req_ready, 2'b01);
        step(); set_req(0, 1'b0, 1'b0, 7'h00, 8'h00); set_req(1, 1'b1, 1'b0, 7'h10, 8'h00);
        rst = 1'b1;
        sample();
        chk("t5_en_in_rst", sram_en, 1'b0);
        chk("t5_ready_in_rst", req_ready, 2'b00);
        chk("t5_rsp_in_rst", rsp_valid, 2'b00);
        step(); sample();
        chk("t5_rsp_drop", rsp_valid, 2'b00);
        chk("t5_rdata_drop", rsp_rdata, 8'h00);

        // Both requesters read after reset: grants 0,1,0,1
        step(); rst = 1'b0; set_req(0, 1'b1, 1'b0, 7'h05, 8'h00);
        sample();
        chk("t2_ready_c0", req_ready, 2'b01);
        chk("t2_en_c0", sram_en, 1'b0);
        chk("t2_rsp_c0", rsp_valid, 2'b00);
        step(); sample();
        chk("t2_ready_c1", req_ready, 2'b10);
        chk("t2_addr_c1", sram_addr, 7'h05);
        chk("t2_rsp_c1", rsp_valid, 2'b00);
        step(); sample();
        chk("t2_ready_c2", req_ready, 2'b01);
        chk("t2_addr_c2", sram_addr, 7'h10);
        chk("t2_rsp_c2", rsp_valid, 2'b01);
        chk("t2_rdata_c2", rsp_rdata, 8'hA5);
        step(); sample();
        chk("t2_ready_c3", req_ready, 2'b10);
        chk("t2_rsp_c3", rsp_valid, 2'b10);
        chk("t2_rdata_c3", rsp_rdata, 8'hEE);
        step(); req_valid = 2'b00; sample();
        chk("t2_rsp_c4", rsp_valid, 2'b01);
        chk("t2_rdata_c4", rsp_rdata, 8'hA5);
        step(); sample();
        chk("t2_rsp_c5", rsp_valid, 2'b10);
        chk("t2_rdata_c5", rsp_rdata, 8'hEE);
        step(); sample();
        chk("t2_rsp_c6", rsp_valid, 2'b00);
        chk("t2_en_c6", sram_en, 1'b0);

        // hold blocks grants while an in-flight read drains
        step(); set_req(0, 1'b1, 1'b0, 7'h05, 8'h00);
        sample();
        chk("t4_ready_pre", req_ready, 2'b01);
        step(); hold = 1'b1; req_valid = 2'b11; sample();
        chk("t4_ready_h0", req_ready, 2'b00);
        chk("t4_en_h0", sram_en, 1'b1);
        step(); sample();
        chk("t4_ready_h1", req_ready, 2'b00);
        chk("t4_rsp_h1", rsp_valid, 2'b01);
        chk("t4_rdata_h1", rsp_rdata, 8'hA5);
        step(); sample();
        chk("t4_ready_h2", req_ready, 2'b00);
        chk("t4_en_h2", sram_en, 1'b0);
        step(); hold = 1'b0; sample();
        chk("t4_ready_post0", req_ready, 2'b10);
        step(); sample();
        chk("t4_ready_post1", req_ready, 2'b01);
        step(); req_valid = 2'b00; sample();
        chk("t4_rsp_post0", rsp_valid, 2'b10);
        chk("t4_rdata_post0", rsp_rdata, 8'hEE);
        step(); sample();
        chk("t4_rsp_post1", rsp_valid, 2'b01);
        chk("t4_rdata_post1", rsp_rdata, 8'hA5);

        // Write by requester 1 interleaved with continuous reads by requester 0
        step(); set_req(0, 1'b1, 1'b0, 7'h7F, 8'h00);
        sample();
        chk("t3_ready_e0", req_ready, 2'b01);
        step(); set_req(1, 1'b1, 1'b1, 7'h7F, 8'h3C);
        sample();
        chk("t3_ready_e1", req_ready, 2'b10);
        chk("t3_wdata_e1", sram_wdata, 8'h3C);
        step(); set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
        sample();
        chk("t3_ready_e2", req_ready, 2'b01);
        chk("t3_rsp_e2", rsp_valid, 2'b01);
        chk("t3_rdata_old", rsp_rdata, 8'hEE);
        chk("t3_wmode_e2", sram_wmode, 1'b1);
        chk("t3_addr_e2", sram_addr, 7'h7F);
        step(); sample();
        chk("t3_ready_e3", req_ready, 2'b01);
        chk("t3_rsp_e3", rsp_valid, 2'b00);
        chk("t3_wmode_e3", sram_wmode, 1'b0);
        step(); req_valid = 2'b00; sample();
        chk("t3_rsp_e4", rsp_valid, 2'b01);
        chk("t3_rdata_new0", rsp_rdata, 8'h3C);
        step(); sample();
        chk("t3_rsp_e5", rsp_valid, 2'b01);
        chk("t3_rdata_new1", rsp_rdata, 8'h3C);
        step(); sample();
        chk("t3_rsp_e6", rsp_valid, 2'b00);
        chk("t3_en_e6", sram_en, 1'b0);

        // Stream 128 writes then 128 reads, alternating requesters
        for (int i = 0; i < 128; i++) begin
            step();
            d  = ~8'(i);
            oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            req_valid = 2'b00;
            set_req(i % 2, 1'b1, 1'b1, 7'(i), d);
            sample();
            chk("t6_wr_ready", req_ready, oh);
            chk("t6_wr_wdata", sram_wdata, d);
            if (i > 0) chk("t6_wr_en", sram_en, 1'b1);
        end
        for (int i = 0; i < 128; i++) begin
            step();
            oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            req_valid = 2'b00;
            set_req(i % 2, 1'b1, 1'b0, 7'(i), 8'h00);
            sample();
            chk("t6_rd_ready", req_ready, oh);
            chk("t6_rd_en", sram_en, 1'b1);
            if (i >= 2) begin
                d = ~8'(i - 2);
                chk("t6_rd_rsp", rsp_valid, ((i - 2) % 2 == 0) ? 2'b01 : 2'b10);
                chk("t6_rd_data", rsp_rdata, d);
            end else begin
                chk("t6_rd_rsp_none", rsp_valid, 2'b00);
            end
        end
        step(); req_valid = 2'b00; sample();
        chk("t6_drain0_rsp", rsp_valid, 2'b01);
        chk("t6_drain0_data", rsp_rdata, 8'h81);
        step(); sample();
        chk("t6_drain1_rsp", rsp_valid, 2'b10);
        chk("t6_drain1_data", rsp_rdata, 8'h80);
        chk("t6_idle_en", sram_en, 1'b0);
        step(); sample();
        chk("t6_drain2_rsp", rsp_valid, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
